// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage
// (master) and the instruction memory (slave).
interface fetch_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  IMemReq_o;
    logic [DATA_WIDTH-1:0] IMemAddr_o;
    logic                  IMemGnt_i;
    logic                  IMemRValid_i;
    logic [DATA_WIDTH-1:0] IMemRData_i;

    modport master (
        output IMemReq_o,
        output IMemAddr_o,
        input  IMemGnt_i,
        input  IMemRValid_i,
        input  IMemRData_i
    );

    modport slave (
        input  IMemReq_o,
        input  IMemAddr_o,
        output IMemGnt_i,
        output IMemRValid_i,
        output IMemRData_i
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one instruction-memory request at a time,
// parks a response in a one-entry skid buffer when decode stalls, and
// drops wrong-path responses after a redirect.
// Optional: define FETCH_PERF_CNT_EN to add the FetchCnt_o delivery counter.
//
// state | meaning
// FETCH | no request outstanding; request PC when the skid buffer is empty
// WAIT  | one request outstanding, its response is on the correct path
// DRAIN | one request outstanding, its response is wrong-path and dropped
module fetch_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    fetch_stage_if.master         imem,
    input  logic                  PCSrc_i,
    input  logic [DATA_WIDTH-1:0] PCTarget_i,
    input  logic                  Stall_i,
    input  logic                  Flush_i,
    output logic [DATA_WIDTH-1:0] InstrD_o,
    output logic [DATA_WIDTH-1:0] PCD_o,
    output logic [DATA_WIDTH-1:0] PCPlus4D_o,
    output logic                  ValidD_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           FetchCnt_o
`endif
);

    localparam logic [DATA_WIDTH-1:0] NOP        = DATA_WIDTH'(32'h0000_0013);
    localparam logic [DATA_WIDTH-1:0] STEP       = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_n;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] req_pc_q;
    logic                  skid_valid_q;
    logic [DATA_WIDTH-1:0] skid_instr_q;
    logic [DATA_WIDTH-1:0] skid_pc_q;
    logic                  req;
    logic                  grant;
    logic                  fresh_rsp;
    logic                  skid_take;
    logic                  ifid_load;

    assign grant     = req && imem.IMemGnt_i;
    // A redirect in the response cycle turns the response into wrong-path data.
    assign fresh_rsp = (state_q == WAIT) && imem.IMemRValid_i && !PCSrc_i;
    // The skid entry belongs to the old path once a redirect arrives.
    assign skid_take = skid_valid_q && !PCSrc_i;
    assign ifid_load = !Flush_i && !Stall_i && (skid_take || fresh_rsp);

    assign imem.IMemReq_o  = req;
    assign imem.IMemAddr_o = pc_q;

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= FETCH;
        else          state_q <= state_n;
    end

    // Next-state and request generation; request is masked during reset.
    always_comb begin
        state_n = state_q;
        req     = 1'b0;
        case (state_q)
            FETCH: begin
                req = rst_n_i && !skid_valid_q;
                if (req && imem.IMemGnt_i) state_n = PCSrc_i ? DRAIN : WAIT;
            end
            WAIT: begin
                if (imem.IMemRValid_i) state_n = FETCH;
                else if (PCSrc_i)      state_n = DRAIN;
            end
            DRAIN: begin
                if (imem.IMemRValid_i) state_n = FETCH;
            end
            default: state_n = FETCH;
        endcase
    end

    // Program counter and PC of the outstanding request; redirect wins over +4.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
        end else begin
            if (PCSrc_i)    pc_q <= PCTarget_i & ALIGN_MASK;
            else if (grant) pc_q <= pc_q + STEP;
            if (grant) req_pc_q <= pc_q;
        end
    end

    // One-entry skid buffer: filled by a response that decode cannot take.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else if (PCSrc_i) begin
            skid_valid_q <= 1'b0;
        end else if (skid_valid_q && !Flush_i && !Stall_i) begin
            skid_valid_q <= 1'b0;
        end else if (fresh_rsp && Stall_i) begin
            skid_valid_q <= 1'b1;
            skid_instr_q <= imem.IMemRData_i;
            skid_pc_q    <= req_pc_q;
        end
    end

    // IF/ID register: flush, then stall, then skid entry, then fresh response.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ValidD_o   <= 1'b0;
            InstrD_o   <= NOP;
            PCD_o      <= '0;
            PCPlus4D_o <= '0;
        end else if (Flush_i) begin
            ValidD_o <= 1'b0;
            InstrD_o <= NOP;
        end else if (!Stall_i) begin
            if (skid_take) begin
                ValidD_o   <= 1'b1;
                InstrD_o   <= skid_instr_q;
                PCD_o      <= skid_pc_q;
                PCPlus4D_o <= skid_pc_q + STEP;
            end else if (fresh_rsp) begin
                ValidD_o   <= 1'b1;
                InstrD_o   <= imem.IMemRData_i;
                PCD_o      <= req_pc_q;
                PCPlus4D_o <= req_pc_q + STEP;
            end else begin
                ValidD_o <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Count of instructions delivered into IF/ID, wrapping at 2^32.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)       FetchCnt_o <= '0;
        else if (ifid_load) FetchCnt_o <= FetchCnt_o + 32'd1;
    end
`else
    logic unused_load;
    assign unused_load = ifid_load;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand-written reset/wrap
// sequences, and a randomized run against a transaction-level model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        PCSrc_i = 1'b0;
    logic [31:0] PCTarget_i = '0;
    logic        Stall_i = 1'b0;
    logic        Flush_i = 1'b0;
    logic [31:0] InstrD_o, PCD_o, PCPlus4D_o;
    logic        ValidD_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] FetchCnt_o;
`endif

    fetch_stage_if #(.DATA_WIDTH(32)) imem ();

    fetch_stage #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .imem       (imem),
        .PCSrc_i    (PCSrc_i),
        .PCTarget_i (PCTarget_i),
        .Stall_i    (Stall_i),
        .Flush_i    (Flush_i),
        .InstrD_o   (InstrD_o),
        .PCD_o      (PCD_o),
        .PCPlus4D_o (PCPlus4D_o),
        .ValidD_o   (ValidD_o)
`ifdef FETCH_PERF_CNT_EN
        ,
        .FetchCnt_o (FetchCnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: actual %h required %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic chk_all(input string tag, input logic ereq, input logic [31:0] eaddr,
                           input logic evalid, input logic [31:0] einstr,
                           input logic [31:0] epcd, input logic [31:0] ep4);
        chk({tag, ".req"},   32'(imem.IMemReq_o), 32'(ereq));
        chk({tag, ".addr"},  imem.IMemAddr_o, eaddr);
        chk({tag, ".valid"}, 32'(ValidD_o), 32'(evalid));
        chk({tag, ".instr"}, InstrD_o, einstr);
        chk({tag, ".pcd"},   PCD_o, epcd);
        chk({tag, ".pcp4"},  PCPlus4D_o, ep4);
    endtask

    task automatic drive(input logic st, input logic fl, input logic ps, input logic [31:0] tg,
                         input logic g, input logic r, input logic [31:0] d);
        Stall_i           = st;
        Flush_i           = fl;
        PCSrc_i           = ps;
        PCTarget_i        = tg;
        imem.IMemGnt_i    = g;
        imem.IMemRValid_i = r;
        imem.IMemRData_i  = d;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    typedef struct {
        logic        st, fl, ps;
        logic [31:0] tg;
        logic        g, r;
        logic [31:0] d;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evalid;
        logic [31:0] einstr, epcd, ep4;
    } vec_t;

    function automatic vec_t mk(input logic st, fl, ps, input logic [31:0] tg,
                                input logic g, r, input logic [31:0] d,
                                input logic ereq, input logic [31:0] eaddr, input logic evalid,
                                input logic [31:0] einstr, epcd, ep4);
        vec_t v;
        v.st = st; v.fl = fl; v.ps = ps; v.tg = tg; v.g = g; v.r = r; v.d = d;
        v.ereq = ereq; v.eaddr = eaddr; v.evalid = evalid;
        v.einstr = einstr; v.epcd = epcd; v.ep4 = ep4;
        return v;
    endfunction

    // Transaction-level reference: an outstanding-request flag with a
    // wrong-path marker, a queue as the skid buffer, and the IF/ID contents.
    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
    ent_t        skidq[$];
    logic        m_out, m_squash, m_valid;
    logic [31:0] m_pc, m_outpc, m_instr, m_pcd, m_p4, m_cnt;

    task automatic model_reset();
        skidq.delete();
        m_out = 0; m_squash = 0; m_valid = 0;
        m_pc = 32'h0; m_outpc = 0; m_instr = NOP; m_pcd = 0; m_p4 = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        logic req, acc, resp, fresh;
        ent_t e;
        req   = !m_out && (skidq.size() == 0);
        acc   = req && imem.IMemGnt_i;
        resp  = m_out && imem.IMemRValid_i;
        fresh = resp && !m_squash && !PCSrc_i;
        if (Flush_i) begin
            m_valid = 0;
            m_instr = NOP;
        end else if (!Stall_i) begin
            if (skidq.size() > 0 && !PCSrc_i) begin
                e = skidq.pop_front();
                m_valid = 1; m_instr = e.instr; m_pcd = e.pc; m_p4 = e.pc + 4; m_cnt++;
            end else if (fresh) begin
                m_valid = 1; m_instr = imem.IMemRData_i; m_pcd = m_outpc; m_p4 = m_outpc + 4; m_cnt++;
            end else begin
                m_valid = 0;
            end
        end
        if (PCSrc_i) skidq.delete();
        else if (fresh && Stall_i) skidq.push_back('{imem.IMemRData_i, m_outpc});
        if (resp) m_out = 0;
        if (PCSrc_i && m_out) m_squash = 1;
        if (acc) begin
            m_out = 1; m_outpc = m_pc; m_squash = PCSrc_i;
        end
        if (PCSrc_i)  m_pc = PCTarget_i & 32'hFFFF_FFFC;
        else if (acc) m_pc = m_pc + 4;
    endtask

    vec_t tbl[24];

    initial begin
        tbl[0]  = mk(0,0,0,0,           1,0,0,            0,32'h004,0,NOP,0,0);
        tbl[1]  = mk(0,0,0,0,           1,1,32'h1000_0000,1,32'h004,1,32'h1000_0000,32'h0,32'h4);
        tbl[2]  = mk(0,0,0,0,           1,1,32'hDEAD_0001,0,32'h008,0,32'h1000_0000,32'h0,32'h4);
        tbl[3]  = mk(0,0,0,0,           1,1,32'h1000_0004,1,32'h008,1,32'h1000_0004,32'h4,32'h8);
        tbl[4]  = mk(0,0,0,0,           1,1,32'hDEAD_0002,0,32'h00C,0,32'h1000_0004,32'h4,32'h8);
        tbl[5]  = mk(0,0,0,0,           1,1,32'h1000_0008,1,32'h00C,1,32'h1000_0008,32'h8,32'hC);
        tbl[6]  = mk(1,0,0,0,           1,0,0,            0,32'h010,1,32'h1000_0008,32'h8,32'hC);
        tbl[7]  = mk(1,0,0,0,           0,1,32'h1000_000C,0,32'h010,1,32'h1000_0008,32'h8,32'hC);
        tbl[8]  = mk(1,0,0,0,           1,0,0,            0,32'h010,1,32'h1000_0008,32'h8,32'hC);
        tbl[9]  = mk(1,0,0,0,           1,0,0,            0,32'h010,1,32'h1000_0008,32'h8,32'hC);
        tbl[10] = mk(0,0,0,0,           1,0,0,            1,32'h010,1,32'h1000_000C,32'hC,32'h10);
        tbl[11] = mk(0,0,0,0,           0,0,0,            1,32'h010,0,32'h1000_000C,32'hC,32'h10);
        tbl[12] = mk(0,0,0,0,           1,0,0,            0,32'h014,0,32'h1000_000C,32'hC,32'h10);
        tbl[13] = mk(0,0,1,32'h103,     0,0,0,            0,32'h100,0,32'h1000_000C,32'hC,32'h10);
        tbl[14] = mk(0,0,0,0,           0,1,32'hDEAD_0003,1,32'h100,0,32'h1000_000C,32'hC,32'h10);
        tbl[15] = mk(0,0,0,0,           1,0,0,            0,32'h104,0,32'h1000_000C,32'hC,32'h10);
        tbl[16] = mk(0,0,0,0,           0,1,32'h1000_0100,1,32'h104,1,32'h1000_0100,32'h100,32'h104);
        tbl[17] = mk(1,1,0,0,           1,0,0,            0,32'h108,0,NOP,32'h100,32'h104);
        tbl[18] = mk(0,0,0,0,           0,1,32'h1000_0104,1,32'h108,1,32'h1000_0104,32'h104,32'h108);
        tbl[19] = mk(0,0,0,0,           1,0,0,            0,32'h10C,0,32'h1000_0104,32'h104,32'h108);
        tbl[20] = mk(0,0,1,32'h200,     0,1,32'hDEAD_0004,1,32'h200,0,32'h1000_0104,32'h104,32'h108);
        tbl[21] = mk(0,0,1,32'h301,     1,0,0,            0,32'h300,0,32'h1000_0104,32'h104,32'h108);
        tbl[22] = mk(0,0,0,0,           0,1,32'hDEAD_0005,1,32'h300,0,32'h1000_0104,32'h104,32'h108);
        tbl[23] = mk(0,0,0,0,           0,1,32'hDEAD_0006,1,32'h300,0,32'h1000_0104,32'h104,32'h108);

        // Reset state, then first request right after release.
        drive(0,0,0,0,0,0,0);
        tick();
        tick();
        chk_all("reset", 0, 32'h0, 0, NOP, 32'h0, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("reset.cnt", FetchCnt_o, 32'h0);
`endif
        rst_n_i = 1'b1;
        #1;
        chk("release.req", 32'(imem.IMemReq_o), 32'h1);
        chk("release.addr", imem.IMemAddr_o, 32'h0);

        // Directed vector table.
        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].st, tbl[i].fl, tbl[i].ps, tbl[i].tg, tbl[i].g, tbl[i].r, tbl[i].d);
            tick();
            chk_all($sformatf("row%0d", i), tbl[i].ereq, tbl[i].eaddr, tbl[i].evalid,
                    tbl[i].einstr, tbl[i].epcd, tbl[i].ep4);
        end

        // PC wrap at the top of the address space.
        drive(0,0,1,32'hFFFF_FFFC,0,0,0);
        tick();
        chk("wrap.addr0", imem.IMemAddr_o, 32'hFFFF_FFFC);
        chk("wrap.req0", 32'(imem.IMemReq_o), 32'h1);
        drive(0,0,0,0,1,0,0);
        tick();
        chk("wrap.addr1", imem.IMemAddr_o, 32'h0000_0000);
        drive(0,0,0,0,0,1,32'h1000_FFFC);
        tick();
        chk_all("wrap.deliver", 1, 32'h0, 1, 32'h1000_FFFC, 32'hFFFF_FFFC, 32'h0);

        // Reset pulsed mid-WAIT, then a stray response after release.
        drive(0,0,0,0,1,0,0);
        tick();
        chk("midwait.addr", imem.IMemAddr_o, 32'h4);
        drive(0,0,0,0,0,0,0);
        #2 rst_n_i = 1'b0;
        #1;
        chk_all("async_rst", 0, 32'h0, 0, NOP, 32'h0, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("async_rst.cnt", FetchCnt_o, 32'h0);
`endif
        tick();
        rst_n_i = 1'b1;
        drive(0,0,0,0,0,1,32'hDEAD_0007);
        #1;
        chk("restart.req", 32'(imem.IMemReq_o), 32'h1);
        tick();
        chk_all("stray", 1, 32'h0, 0, NOP, 32'h0, 32'h0);
        drive(0,0,0,0,1,0,0);
        tick();
        chk("restart.addr", imem.IMemAddr_o, 32'h4);
        drive(0,0,0,0,0,1,32'h1000_0000);
        tick();
        chk_all("restart.deliver", 1, 32'h4, 1, 32'h1000_0000, 32'h0, 32'h4);
`ifdef FETCH_PERF_CNT_EN
        chk("restart.cnt", FetchCnt_o, 32'h1);
`endif

        // Randomized run against the reference model.
        drive(0,0,0,0,0,0,0);
        rst_n_i = 1'b0;
        tick();
        rst_n_i = 1'b1;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom % 4) == 0, ($urandom % 10) == 0, ($urandom % 12) == 0, $urandom,
                  ($urandom % 2) == 0, ($urandom % 3) != 0, $urandom);
            model_edge();
            tick();
            chk_all($sformatf("rand%0d", c), !m_out && (skidq.size() == 0), m_pc,
                    m_valid, m_instr, m_pcd, m_p4);
`ifdef FETCH_PERF_CNT_EN
            chk($sformatf("rand%0d.cnt", c), FetchCnt_o, m_cnt);
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the instruction/address width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-003 SHALL have clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have rst_n_i  input  1  asynchronous, active-low reset.
REQ-005 SHALL have PCSrc_i  input  1  redirect request: branch/jump taken.
REQ-006 SHALL have PCTarget_i  input  DATA_WIDTH  redirect address.
REQ-007 SHALL have Stall_i  input  1  decode not ready; hold IF/ID.
REQ-008 SHALL have Flush_i  input  1  squash the IF/ID contents.
REQ-009 SHALL have IMemReq_o  output  1  fetch request valid.
REQ-010 SHALL have IMemAddr_o  output  DATA_WIDTH  fetch address.
REQ-011 SHALL have IMemGnt_i  input  1  request accepted this cycle.
REQ-012 SHALL have IMemRValid_i  input  1  read data valid.
REQ-013 SHALL have IMemRData_i  input  DATA_WIDTH  fetched instruction.
REQ-014 SHALL have InstrD_o, PCD_o, PCPlus4D_o  output  DATA_WIDTH each  IF/ID instruction, its PC, PC+4.
REQ-015 SHALL have ValidD_o  output  1  IF/ID holds a real instruction.

Function
REQ-016 SHALL implement FSM states FETCH, WAIT, DRAIN, with at most one outstanding memory request.
REQ-017 FETCH: IMemReq_o=1 and IMemAddr_o=PC when the skid buffer is empty; on IMemGnt_i latch reqPC=PC, PC<=PC+4, go WAIT.
REQ-018 WAIT/DRAIN: IMemReq_o SHALL be 0.
REQ-019 WAIT: on IMemRValid_i go FETCH; data goes to IF/ID if Stall_i=0, else into the one-entry skid buffer.
REQ-020 DRAIN: on IMemRValid_i discard the data and go FETCH.
REQ-021 PCSrc_i=1 SHALL load PC<=PCTarget_i with bits [1:0] forced to 00, taking priority over PC+4.
REQ-022 PCSrc_i=1 SHALL clear the skid buffer.
REQ-023 PCSrc_i=1 in WAIT without IMemRValid_i SHALL go DRAIN.
REQ-024 PCSrc_i=1 in the same cycle as IMemRValid_i SHALL discard the data and go FETCH.
REQ-025 PCSrc_i=1 in FETCH together with IMemGnt_i SHALL go DRAIN.
REQ-026 IF/ID update priority: Flush_i (ValidD_o<=0, InstrD_o<=32'h0000_0013), then Stall_i (hold all), then skid entry, then fresh response, else bubble (ValidD_o<=0, data held).
REQ-027 PCD_o SHALL equal reqPC of the delivered instruction; PCPlus4D_o SHALL equal PCD_o+4.
REQ-028 Fetch latency: grant in cycle N plus response in cycle N+k SHALL give ValidD_o=1 in cycle N+k+1 when not stalled.
REQ-029 PC arithmetic SHALL be modulo 2^DATA_WIDTH; 32'hFFFF_FFFC+4 wraps to 0.
REQ-030 IMemRValid_i in FETCH with no outstanding request SHALL be ignored.

Reset
REQ-031 rst_n_i=0 SHALL immediately set PC=RESET_PC, state FETCH, skid empty, IMemReq_o=0, ValidD_o=0, InstrD_o=32'h0000_0013, PCD_o=0, PCPlus4D_o=0.
REQ-032 A reset asserted during WAIT SHALL drop the outstanding request; a response arriving after reset release SHALL be ignored (REQ-030).
REQ-033 The first request SHALL be issued in the first cycle after rst_n_i deasserts.

Configuration
REQ-034 Macro FETCH_PERF_CNT_EN defined: SHALL add output FetchCnt_o (32 bits, reset 0), incremented on each cycle ValidD_o transitions into a newly delivered instruction, wrapping at 2^32.
REQ-035 Macro FETCH_PERF_CNT_EN undefined: the FetchCnt_o port and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-036 Reset release, grant and rvalid held 1 -> IMemAddr_o sequence 0,4,8; PCD_o 0,4,8 with ValidD_o=1 and PCPlus4D_o=PCD_o+4.
REQ-037 Response arrives with Stall_i=1 for 3 cycles -> IF/ID held, IMemReq_o=0 while the skid buffer is full, skid entry delivered on the first unstalled cycle, no instruction lost or duplicated.
REQ-038 PCSrc_i=1 with PCTarget_i=32'h0000_0103 while in WAIT -> next response discarded, next IMemAddr_o=32'h0000_0100, no ValidD_o for the squashed fetch.
REQ-039 Flush_i and Stall_i asserted together -> ValidD_o=0 and InstrD_o=32'h0000_0013 on the next edge.
REQ-040 PC=32'hFFFF_FFFC granted -> following IMemAddr_o=32'h0000_0000.
REQ-041 rst_n_i pulsed low mid-WAIT, then a stray IMemRValid_i -> outputs at reset values, stray data ignored, fetch restarts at RESET_PC; with FETCH_PERF_CNT_EN, FetchCnt_o=0 after reset.
